frame_fifo: RTL and testbench

FRAME_FIFO -- requirements
Module: frame_fifo

---
 rtl/frame_fifo_pkg.sv | 18 +
 rtl/frame_fifo_mem.sv | 28 ++
 rtl/frame_fifo.sv | 113 +++++++++++
 tb/tb_frame_fifo.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fifo_pkg.sv
// Shared definitions for the frame FIFO: default sizes, flag offsets within an
// entry and the packed entry layout {first, last, data}.
package frame_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1024;

    // Flag positions counted from the top of the data field: entry[DATA_W + offset]
    localparam int LAST_BIT  = 0;
    localparam int FIRST_BIT = 1;

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/frame_fifo_mem.sv
// Frame FIFO storage: one synchronous write port and an asynchronous read of
// the head entry. Contents are deliberately not reset.
module frame_fifo_mem
    import frame_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 2,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/frame_fifo.sv
// Frame-aware byte FIFO tagging each entry with first/last-of-frame flags.
// Define FRAME_FIFO_DROP_FRAME_EN to discard the rest of a frame after an overflow drop.
module frame_fifo
    import frame_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    input  logic                     din_last,
    input  logic                     stop,
    output logic [DATA_W-1:0]        byte_out,
    output logic                     push_byte,
    output logic                     sync,
    output logic                     last_byte,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 2;

    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          next_first;
    logic          refuse;
    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level = wptr - rptr;
    assign rd_en = !empty && !stop;

`ifdef FRAME_FIFO_DROP_FRAME_EN
    logic dropping;

    assign refuse = din_valid && (full || dropping);

    // Once a beat is refused, keep refusing until that frame's last beat has gone by
    always_ff @(posedge clk) begin
        if (reset) begin
            dropping <= 1'b0;
        end else if (refuse) begin
            dropping <= !din_last;
        end
    end
`else
    assign refuse = din_valid && full;
`endif

    assign wr_en = din_valid && !refuse;

    always_comb begin
        wr_entry                      = '0;
        wr_entry[DATA_W-1:0]          = din;
        wr_entry[DATA_W + LAST_BIT]   = din_last;
        wr_entry[DATA_W + FIRST_BIT]  = next_first;
    end

    frame_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rptr[AW-1:0]),
        .rdata (head)
    );

    // Frame tracking follows every write request, dropped or not
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            next_first <= 1'b1;
            overflow   <= 1'b0;
            push_byte  <= 1'b0;
            sync       <= 1'b0;
            last_byte  <= 1'b0;
            byte_out   <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (din_valid) begin
                next_first <= din_last;
            end
            if (refuse) begin
                overflow <= 1'b1;
            end
            push_byte <= rd_en;
            sync      <= rd_en && head[DATA_W + FIRST_BIT];
            last_byte <= rd_en && head[DATA_W + LAST_BIT];
            if (rd_en) begin
                rptr     <= rptr + 1'b1;
                byte_out <= head[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo.sv
// Self-checking bench for frame_fifo (DEPTH=4) using an expected-output queue.
module tb_frame_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic [DW-1:0] din       = '0;
    logic          din_valid = 1'b0;
    logic          din_last  = 1'b0;
    logic          stop      = 1'b0;
    logic [DW-1:0] byte_out;
    logic          push_byte;
    logic          sync;
    logic          last_byte;
    logic          full;
    logic          empty;
    logic [2:0]    level;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q [$];

    frame_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .stop      (stop),
        .byte_out  (byte_out),
        .push_byte (push_byte),
        .sync      (sync),
        .last_byte (last_byte),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic s);
        din_valid = v;
        din       = d;
        din_last  = l;
        stop      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if ({push_byte, sync, last_byte} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {push_byte, sync, last_byte}); end
        n_checks++; if (byte_out !== '0) begin n_fail++; $display("FAIL reset_byte_out: got %h want 00", byte_out); end
        reset = 1'b0;
    endtask

    task automatic test_frame();
        int pushes = 0;
        int prev   = -1;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                exp_q.push_back({c == 0, c == 2, 8'(8'hA1 + c)});
                drive(1'b1, 8'(8'hA1 + c), c == 2, 1'b0);
            end else begin
                drive(1'b0, '0, 1'b0, 1'b0);
            end
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL frame_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL frame_data: got %h want %h", got, exp); end
                end
                n_checks++;
                if (prev >= 0 && c != prev + 1) begin n_fail++; $display("FAIL frame_gap: got cycle %0d want %0d", c, prev + 1); end
                prev = c;
                pushes++;
            end
        end
        n_checks++; if (pushes != 3) begin n_fail++; $display("FAIL frame_count: got %0d want 3", pushes); end
    endtask

    task automatic test_overflow();
        int pushes = 0;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) exp_q.push_back({c == 0, 1'b0, 8'(8'hB0 + c)});
            drive(1'b1, 8'(8'hB0 + c), c == 5, 1'b1);
            if (c == 2) begin
                n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_early: got %b want 0", full); end
            end
            if (c == 3) begin
                n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full_4th: got %b want 1", full); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_overflow_early: got %b want 0", overflow); end
            end
            n_checks++; if (push_byte !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_while_stop: got %b want 0", push_byte); end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_overflow: got %b want 1", overflow); end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL ovf_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL ovf_data: got %h want %h", got, exp); end
                end
                pushes++;
            end
        end
        n_checks++; if (pushes != 4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", pushes); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_full_write_pop();
        int pushes = 0;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            exp_q.push_back({c == 0, 1'b0, 8'(8'hC0 + c)});
            drive(1'b1, 8'(8'hC0 + c), 1'b0, 1'b1);
        end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fwp_level_before: got %0d want 4", level); end
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive(1'b1, 8'hC4, 1'b1, 1'b0);
            else        drive(1'b0, '0, 1'b0, 1'b0);
            if (c == 0) begin
                n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL fwp_level_after: got %0d want 3", level); end
                n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fwp_overflow: got %b want 1", overflow); end
            end
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL fwp_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL fwp_data: got %h want %h", got, exp); end
                end
                pushes++;
            end
        end
        n_checks++; if (pushes != 4) begin n_fail++; $display("FAIL fwp_count: got %0d want 4", pushes); end
    endtask

    task automatic test_wrap();
        localparam int N = 2 * DEPTH + 3;
        int pushes = 0;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < N + 4; c++) begin
            if (c < N) begin
                exp_q.push_back({c == 0, c == N - 1, 8'(8'h10 + c)});
                drive(1'b1, 8'(8'h10 + c), c == N - 1, 1'b0);
                n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got %b want 0 at cycle %0d", empty, c); end
            end else begin
                drive(1'b0, '0, 1'b0, 1'b0);
            end
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL wrap_data: got %h want %h", got, exp); end
                end
                pushes++;
            end
        end
        n_checks++; if (pushes != N) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", pushes, N); end
    endtask

    task automatic test_frame_drop();
        int pushes = 0;
        int want   = 0;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            if (c < 8) begin
`ifdef FRAME_FIFO_DROP_FRAME_EN
                if (c < 4) exp_q.push_back({c == 0, 1'b0, 8'(8'hD1 + c)});
`else
                if (c != 4) exp_q.push_back({c == 0, c == 7, 8'(8'hD1 + c)});
`endif
                drive(1'b1, 8'(8'hD1 + c), c == 7, c < 4);
            end else if (c == 8) begin
                exp_q.push_back({1'b1, 1'b1, 8'hE0});
                drive(1'b1, 8'hE0, 1'b1, 1'b0);
            end else begin
                drive(1'b0, '0, 1'b0, 1'b0);
            end
            if (c == 8) want = exp_q.size() + pushes;
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL drop_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL drop_data: got %h want %h", got, exp); end
                end
                pushes++;
            end
        end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow: got %b want 1", overflow); end
        n_checks++; if (pushes != want) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", pushes, want); end
    endtask

    task automatic test_reset_mid();
        int pushes = 0;
        logic [DW+1:0] got, exp;
        apply_reset();
        for (int c = 0; c < 3; c++) drive(1'b1, 8'(8'hF1 + c), 1'b0, 1'b1);
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL rmid_level_before: got %0d want 3", level); end
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmid_empty: got %b want 1", empty); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL rmid_level: got %0d want 0", level); end
        n_checks++; if (push_byte !== 1'b0) begin n_fail++; $display("FAIL rmid_push: got %b want 0", push_byte); end
        exp_q.push_back({1'b1, 1'b0, 8'h5A});
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 8'h5A, 1'b0, 1'b0);
            else        drive(1'b0, '0, 1'b0, 1'b0);
            if (push_byte) begin
                got = {sync, last_byte, byte_out};
                n_checks++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rmid_extra: got %h want none", got); end
                else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin n_fail++; $display("FAIL rmid_data: got %h want %h", got, exp); end
                end
                pushes++;
            end
        end
        n_checks++; if (pushes != 1) begin n_fail++; $display("FAIL rmid_count: got %0d want 1", pushes); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_full_write_pop();
        test_wrap();
        test_frame_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
